// File: rtl/watch_pkg.sv
// Shared constants for the watch timekeeping and display stages.
package watch_pkg;

  localparam logic MODE_NORMAL  = 1'b0;
  localparam logic MODE_SETTING = 1'b1;

  localparam logic [2:0] POS_HOUR = 3'b100;
  localparam logic [2:0] POS_MIN  = 3'b010;
  localparam logic [2:0] POS_SEC  = 3'b001;
  localparam logic [2:0] POS_NONE = 3'b000;

  localparam int DEF_HOUR_MAX = 23;
  localparam int DEF_MIN_MAX  = 59;

  typedef enum logic [1:0] {
    ST_NORMAL,
    ST_SET_HOUR,
    ST_SET_MIN,
    ST_SET_SEC
  } watch_state_t;

  // Field increment that rolls over to zero after its maximum, with no carry.
  function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max_val);
    return (value >= max_val) ? 6'd0 : value + 6'd1;
  endfunction

endpackage

// File: rtl/watch_key_ctrl.sv
// Button edge detection and increment hold/auto-repeat pacing for the watch.
module watch_key_ctrl
  import watch_pkg::*;
#(
  parameter int REPEAT_DLY = 2
) (
  input  logic reset,
  input  logic clk2hz,
  input  logic sw_mode,
  input  logic sw_pos,
  input  logic sw_inc,
  input  logic setting,
  output logic mode_evt,
  output logic pos_evt,
  output logic inc_evt
);

  localparam int             CW  = $clog2(REPEAT_DLY + 1);
  localparam logic [CW-1:0]  DLY = CW'(REPEAT_DLY);

  logic          prev_mode;
  logic          prev_pos;
  logic          prev_inc;
  logic [CW-1:0] hold_cnt;
  logic          mode_edge;
  logic          pos_edge;
  logic          inc_edge;
  logic          inc_repeat;

  assign mode_edge  = sw_mode & ~prev_mode;
  assign pos_edge   = sw_pos & ~prev_pos;
  assign inc_edge   = sw_inc & ~prev_inc;
  assign inc_repeat = sw_inc & prev_inc & (hold_cnt == DLY);

  // mode beats pos beats inc; pos and inc only matter while setting
  assign mode_evt = mode_edge;
  assign pos_evt  = setting & pos_edge & ~mode_edge;
  assign inc_evt  = setting & ~mode_edge & ~pos_evt & (inc_edge | inc_repeat);

  // A zero count while the button stays high means "locked until a fresh press".
  always_ff @(posedge clk2hz or negedge reset) begin
    if (!reset) begin
      prev_mode <= 1'b0;
      prev_pos  <= 1'b0;
      prev_inc  <= 1'b0;
      hold_cnt  <= '0;
    end else begin
      prev_mode <= sw_mode;
      prev_pos  <= sw_pos;
      prev_inc  <= sw_inc;
      if (mode_evt || pos_evt || !sw_inc)
        hold_cnt <= '0;
      else if (inc_edge)
        hold_cnt <= CW'(1);
      else if (hold_cnt != '0 && hold_cnt != DLY)
        hold_cnt <= hold_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/watch_time_core.sv
// Watch timekeeping counters and the normal/setting mode state machine.
module watch_time_core
  import watch_pkg::*;
#(
  parameter int HOUR_MAX   = DEF_HOUR_MAX,
  parameter int MIN_MAX    = DEF_MIN_MAX,
  parameter int REPEAT_DLY = 2
) (
  input  logic       reset,
  input  logic       clk2hz,
  input  logic       sw_mode,
  input  logic       sw_pos,
  input  logic       sw_inc,
  output logic       mode,
  output logic [2:0] set_pos,
  output logic [4:0] dc_hour,
  output logic [5:0] dc_min,
  output logic [5:0] dc_sec,
  output logic       tick_1hz
);

  localparam logic [5:0] H_MAX = 6'(HOUR_MAX);
  localparam logic [5:0] M_MAX = 6'(MIN_MAX);

  watch_state_t state;
  logic         phase;
  logic         mode_evt;
  logic         pos_evt;
  logic         inc_evt;

  watch_key_ctrl #(.REPEAT_DLY(REPEAT_DLY)) u_keys (
    .reset    (reset),
    .clk2hz   (clk2hz),
    .sw_mode  (sw_mode),
    .sw_pos   (sw_pos),
    .sw_inc   (sw_inc),
    .setting  (mode),
    .mode_evt (mode_evt),
    .pos_evt  (pos_evt),
    .inc_evt  (inc_evt)
  );

  // Any mode change restarts the half-second phase so the first second after
  // leaving setting mode takes a full two ticks.
  always_ff @(posedge clk2hz or negedge reset) begin
    if (!reset) begin
      state    <= ST_NORMAL;
      mode     <= MODE_NORMAL;
      set_pos  <= POS_NONE;
      dc_hour  <= '0;
      dc_min   <= '0;
      dc_sec   <= '0;
      phase    <= 1'b0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= 1'b0;
      if (mode_evt) begin
        phase <= 1'b0;
        if (state == ST_NORMAL) begin
          state   <= ST_SET_HOUR;
          mode    <= MODE_SETTING;
          set_pos <= POS_HOUR;
        end else begin
          state   <= ST_NORMAL;
          mode    <= MODE_NORMAL;
          set_pos <= POS_NONE;
        end
      end else begin
        case (state)
          ST_NORMAL: begin
            phase <= ~phase;
            if (phase) begin
              tick_1hz <= 1'b1;
              dc_sec   <= wrap_inc(dc_sec, M_MAX);
              if (dc_sec == M_MAX) begin
                dc_min <= wrap_inc(dc_min, M_MAX);
                if (dc_min == M_MAX)
                  dc_hour <= 5'(wrap_inc({1'b0, dc_hour}, H_MAX));
              end
            end
          end
          ST_SET_HOUR: begin
            if (pos_evt) begin
              state   <= ST_SET_MIN;
              set_pos <= POS_MIN;
            end else if (inc_evt) begin
              dc_hour <= 5'(wrap_inc({1'b0, dc_hour}, H_MAX));
            end
          end
          ST_SET_MIN: begin
            if (pos_evt) begin
              state   <= ST_SET_SEC;
              set_pos <= POS_SEC;
            end else if (inc_evt) begin
              dc_min <= wrap_inc(dc_min, M_MAX);
            end
          end
          ST_SET_SEC: begin
            if (pos_evt) begin
              state   <= ST_SET_HOUR;
              set_pos <= POS_HOUR;
            end else if (inc_evt) begin
              dc_sec <= wrap_inc(dc_sec, M_MAX);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_watch_time_core.sv
// Directed and randomized checks of watch_time_core against a seconds-of-day model.
module tb_watch_time_core;

  logic       reset;
  logic       clk2hz;
  logic       sw_mode;
  logic       sw_pos;
  logic       sw_inc;
  logic       mode;
  logic [2:0] set_pos;
  logic [4:0] dc_hour;
  logic [5:0] dc_min;
  logic [5:0] dc_sec;
  logic       tick_1hz;

  int vectors;
  int miscompares;
  int pulse_cnt;

  // reference model state: time as seconds of day, field 0/1/2 = hour/min/sec
  int m_t;
  bit m_set;
  int m_fld;
  bit m_phase;
  bit m_tick;
  bit m_pm, m_pp, m_pi;
  int m_held;

  watch_time_core dut (
    .reset    (reset),
    .clk2hz   (clk2hz),
    .sw_mode  (sw_mode),
    .sw_pos   (sw_pos),
    .sw_inc   (sw_inc),
    .mode     (mode),
    .set_pos  (set_pos),
    .dc_hour  (dc_hour),
    .dc_min   (dc_min),
    .dc_sec   (dc_sec),
    .tick_1hz (tick_1hz)
  );

  initial clk2hz = 1'b0;
  always #5 clk2hz = ~clk2hz;

  function automatic int m_hour();
    return m_t / 3600;
  endfunction

  function automatic int m_min();
    return (m_t / 60) % 60;
  endfunction

  function automatic int m_sec();
    return m_t % 60;
  endfunction

  function automatic logic [31:0] m_pos();
    if (!m_set) return 32'd0;
    case (m_fld)
      0:       return 32'd4;
      1:       return 32'd2;
      default: return 32'd1;
    endcase
  endfunction

  task automatic model_reset();
    m_t = 0; m_set = 0; m_fld = 0; m_phase = 0; m_tick = 0;
    m_pm = 0; m_pp = 0; m_pi = 0; m_held = 0;
  endtask

  task automatic model_bump();
    int h, mi, s;
    h = m_hour(); mi = m_min(); s = m_sec();
    case (m_fld)
      0:       h  = (h + 1) % 24;
      1:       mi = (mi + 1) % 60;
      default: s  = (s + 1) % 60;
    endcase
    m_t = h * 3600 + mi * 60 + s;
  endtask

  task automatic model_tick(input bit bm, input bit bp, input bit bi);
    bit me, pe, ie;
    me = bm && !m_pm;
    pe = bp && !m_pp;
    ie = bi && !m_pi;
    m_tick = 0;
    if (me) begin
      m_set = !m_set; m_fld = 0; m_phase = 0; m_held = 0;
    end else if (!m_set) begin
      if (m_phase) begin
        m_t = (m_t + 1) % 86400;
        m_tick = 1;
      end
      m_phase = !m_phase;
    end else if (pe) begin
      m_fld = (m_fld + 1) % 3;
      m_held = 0;
    end else if (ie) begin
      m_held = 1;
      model_bump();
    end else if (bi && m_held > 0) begin
      m_held++;
      if (m_held >= 3) model_bump();
    end else if (!bi) begin
      m_held = 0;
    end
    m_pm = bm; m_pp = bp; m_pi = bi;
  endtask

  task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    cmp({tag, ".mode"},     32'(mode),     32'(m_set));
    cmp({tag, ".set_pos"},  32'(set_pos),  m_pos());
    cmp({tag, ".hour"},     32'(dc_hour),  32'(m_hour()));
    cmp({tag, ".min"},      32'(dc_min),   32'(m_min()));
    cmp({tag, ".sec"},      32'(dc_sec),   32'(m_sec()));
    cmp({tag, ".tick_1hz"}, 32'(tick_1hz), 32'(m_tick));
  endtask

  task automatic step(input bit bm, input bit bp, input bit bi);
    sw_mode = bm; sw_pos = bp; sw_inc = bi;
    @(posedge clk2hz);
    model_tick(bm, bp, bi);
    #1;
    check_all("step");
    if (tick_1hz === 1'b1) pulse_cnt++;
  endtask

  // from NORMAL, load a time and stay in SET_SEC with buttons released
  task automatic set_time(input int h, input int mi, input int s);
    step(1, 0, 0); step(0, 0, 0);
    while (m_hour() != h) begin step(0, 0, 1); step(0, 0, 0); end
    step(0, 1, 0); step(0, 0, 0);
    while (m_min() != mi) begin step(0, 0, 1); step(0, 0, 0); end
    step(0, 1, 0); step(0, 0, 0);
    while (m_sec() != s) begin step(0, 0, 1); step(0, 0, 0); end
  endtask

  initial begin
    vectors = 0; miscompares = 0; pulse_cnt = 0;
    reset = 1'b0; sw_mode = 0; sw_pos = 0; sw_inc = 0;
    model_reset();
    #3;
    check_all("reset");
    #4 reset = 1'b1;

    $display("[TB] idle timekeeping");
    repeat (240) step(0, 0, 0);
    cmp("idle.hour", 32'(dc_hour), 0);
    cmp("idle.min", 32'(dc_min), 2);
    cmp("idle.sec", 32'(dc_sec), 0);
    cmp("idle.pulses", pulse_cnt, 120);

    $display("[TB] full carry wrap");
    set_time(23, 59, 58);
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    cmp("wrap.hour", 32'(dc_hour), 0);
    cmp("wrap.min", 32'(dc_min), 0);
    cmp("wrap.sec", 32'(dc_sec), 0);

    $display("[TB] field selection");
    step(1, 0, 0);
    cmp("sel.mode", 32'(mode), 1);
    cmp("sel.pos0", 32'(set_pos), 32'b100);
    step(0, 1, 0);
    cmp("sel.pos1", 32'(set_pos), 32'b010);
    step(0, 0, 0); step(0, 1, 0);
    cmp("sel.pos2", 32'(set_pos), 32'b001);
    step(0, 0, 0); step(0, 1, 0);
    cmp("sel.pos3", 32'(set_pos), 32'b100);
    repeat (3) step(0, 0, 0);
    cmp("sel.frozen", 32'(dc_sec), 0);
    step(1, 0, 0); step(0, 0, 0);

    $display("[TB] hold auto-repeat");
    set_time(0, 0, 58);
    step(0, 0, 1); cmp("hold.t1", 32'(dc_sec), 59);
    step(0, 0, 1); cmp("hold.t2", 32'(dc_sec), 59);
    step(0, 0, 1); cmp("hold.t3", 32'(dc_sec), 0);
    step(0, 0, 1); cmp("hold.t4", 32'(dc_sec), 1);
    step(0, 0, 1); cmp("hold.t5", 32'(dc_sec), 2);
    cmp("hold.min", 32'(dc_min), 0);
    step(0, 0, 0); step(1, 0, 0); step(0, 0, 0);

    $display("[TB] mode beats inc");
    step(1, 0, 0); step(0, 0, 0); step(0, 1, 0); step(0, 0, 0);
    step(1, 0, 1);
    cmp("prio.mode", 32'(mode), 0);
    cmp("prio.min", 32'(dc_min), 0);
    step(0, 0, 0);

    $display("[TB] async reset mid-hold");
    set_time(11, 34, 56);
    step(0, 1, 0); step(0, 0, 0);
    step(0, 0, 1); step(0, 0, 1);
    cmp("rst.pre_hour", 32'(dc_hour), 12);
    #2 reset = 1'b0;
    #1;
    model_reset();
    check_all("rst.async");
    cmp("rst.set_pos", 32'(set_pos), 0);
    @(posedge clk2hz);
    #1 check_all("rst.held");
    reset = 1'b1;
    step(1, 0, 1);
    cmp("rst.edge_after", 32'(mode), 1);

    $display("[TB] random buttons");
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 11) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
